// File: rtl/kvs.sv
// rtl/kvs.sv - pipelined d-left hash map with insert, lookup and forwarded modify/delete.
// Optional KVS_FORMAL_EN: adds f_key input and internal consistency assertions.
module kvs #(
    parameter int NUM_KEY_BITS  = 8,
    parameter int NUM_VAL_BITS  = 8,
    parameter int NUM_PIPES     = 2,
    parameter int NUM_TABLES    = 2,
    parameter int NUM_ADDR_BITS = 4,
    parameter int EN_INS_SEL    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef KVS_FORMAL_EN
    input  logic [NUM_KEY_BITS-1:0] f_key,
`endif
    output logic                    busy,
    input  logic                    insert,
    input  logic [NUM_KEY_BITS-1:0] ins_key,
    input  logic [NUM_VAL_BITS-1:0] ins_value,
    input  logic                    lookup,
    input  logic [NUM_KEY_BITS-1:0] key,
    input  logic                    modify,
    input  logic                    del,
    input  logic [NUM_VAL_BITS-1:0] mod_value,
    output logic                    valid,
    output logic [NUM_VAL_BITS-1:0] res
);
    localparam int SLOTS = 1 << NUM_ADDR_BITS;
    localparam int TW    = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;

    typedef struct packed {
        logic                     hit;
        logic [TW-1:0]            tbl;
        logic [NUM_ADDR_BITS-1:0] addr;
        logic [NUM_VAL_BITS-1:0]  val;
    } ent_t;

    logic                    occ_q [NUM_TABLES][SLOTS];
    logic                    occ_d [NUM_TABLES][SLOTS];
    logic [NUM_KEY_BITS-1:0] key_q [NUM_TABLES][SLOTS];
    logic [NUM_KEY_BITS-1:0] key_d [NUM_TABLES][SLOTS];
    logic [NUM_VAL_BITS-1:0] val_q [NUM_TABLES][SLOTS];
    logic [NUM_VAL_BITS-1:0] val_d [NUM_TABLES][SLOTS];

    ent_t pipe_q [NUM_PIPES];
    ent_t pipe_d [NUM_PIPES];
    ent_t chain  [NUM_PIPES+1];
    ent_t lk;
    ent_t out_e;

    logic                     busy_q, busy_d;
    logic [TW-1:0]            rr_q, rr_d;
    logic                     ins_acc, ins_do, mod_en;
    logic [TW-1:0]            ins_t;
    logic [NUM_ADDR_BITS-1:0] ins_a;

    // Rotate left by the table index, then XOR-fold LSB-first chunks into the address.
    function automatic logic [NUM_ADDR_BITS-1:0] hash(input logic [NUM_KEY_BITS-1:0] k, input int i);
        logic [NUM_KEY_BITS-1:0]  r;
        logic [NUM_ADDR_BITS-1:0] h;
        int                       s;
        s = i % NUM_KEY_BITS;
        r = (k << s) | (k >> (NUM_KEY_BITS - s));
        h = '0;
        for (int b = 0; b < NUM_KEY_BITS; b++) begin
            h[b % NUM_ADDR_BITS] = h[b % NUM_ADDR_BITS] ^ r[b];
        end
        return h;
    endfunction

    assign out_e  = pipe_q[NUM_PIPES-1];
    assign valid  = out_e.hit;
    assign res    = out_e.val;
    assign busy   = busy_q;
    assign mod_en = modify && out_e.hit;
    assign ins_acc = insert && !busy_q;

    always_comb begin
        lk = '0;
        for (int i = NUM_TABLES - 1; i >= 0; i--) begin
            if (occ_q[i][hash(key, i)] && key_q[i][hash(key, i)] == key) begin
                lk.hit  = lookup;
                lk.tbl  = TW'(i);
                lk.addr = hash(key, i);
                lk.val  = val_q[i][hash(key, i)];
            end
        end
        if (!lookup) begin
            lk = '0;
        end
    end

    always_comb begin
        ins_do = 1'b0;
        ins_t  = '0;
        ins_a  = '0;
        rr_d   = rr_q;
        if (EN_INS_SEL != 0) begin
            for (int i = NUM_TABLES - 1; i >= 0; i--) begin
                if (!occ_q[i][hash(ins_key, i)]) begin
                    ins_do = ins_acc;
                    ins_t  = TW'(i);
                    ins_a  = hash(ins_key, i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_TABLES; i++) begin
                if (TW'(i) == rr_q && !occ_q[i][hash(ins_key, i)]) begin
                    ins_do = ins_acc;
                    ins_t  = TW'(i);
                    ins_a  = hash(ins_key, i);
                end
            end
            if (ins_acc) begin
                rr_d = (rr_q == TW'(NUM_TABLES - 1)) ? '0 : rr_q + 1'b1;
            end
        end
        busy_d = ins_acc;
    end

    // Modify and insert never target the same slot: one needs it occupied, the other free.
    always_comb begin
        occ_d = occ_q;
        key_d = key_q;
        val_d = val_q;
        if (mod_en) begin
            if (del) begin
                occ_d[out_e.tbl][out_e.addr] = 1'b0;
            end else begin
                val_d[out_e.tbl][out_e.addr] = mod_value;
            end
        end
        if (ins_do) begin
            occ_d[ins_t][ins_a] = 1'b1;
            key_d[ins_t][ins_a] = ins_key;
            val_d[ins_t][ins_a] = ins_value;
        end
    end

    // Forward the presented modify/delete into younger entries aimed at the same slot.
    always_comb begin
        chain[0] = lk;
        for (int k = 0; k < NUM_PIPES; k++) begin
            chain[k+1] = pipe_q[k];
        end
        for (int k = 0; k < NUM_PIPES; k++) begin
            pipe_d[k] = chain[k];
            if (mod_en && chain[k].hit && chain[k].tbl == out_e.tbl && chain[k].addr == out_e.addr) begin
                if (del) begin
                    pipe_d[k].hit = 1'b0;
                end else begin
                    pipe_d[k].val = mod_value;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            rr_q   <= '0;
            for (int i = 0; i < NUM_TABLES; i++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    occ_q[i][s] <= 1'b0;
                end
            end
            for (int k = 0; k < NUM_PIPES; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            rr_q   <= rr_d;
            occ_q  <= occ_d;
            pipe_q <= pipe_d;
        end
    end

    always_ff @(posedge clk) begin
        key_q <= key_d;
        val_q <= val_d;
    end

`ifdef KVS_FORMAL_EN
    always_comb begin
        int n;
        n = 0;
        for (int i = 0; i < NUM_TABLES; i++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (occ_q[i][s] && key_q[i][s] == f_key) begin
                    n = n + 1;
                end
            end
        end
        assert (n <= 1);
        for (int k = 0; k < NUM_PIPES; k++) begin
            if (pipe_q[k].hit && key_q[pipe_q[k].tbl][pipe_q[k].addr] == f_key) begin
                assert (occ_q[pipe_q[k].tbl][pipe_q[k].addr] &&
                        val_q[pipe_q[k].tbl][pipe_q[k].addr] == pipe_q[k].val);
            end
        end
    end
`endif
endmodule

// File: tb/tb_kvs.sv
// tb/tb_kvs.sv - directed self-checking bench for kvs.
module tb_kvs;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic       insert;
    logic [7:0] ins_key;
    logic [7:0] ins_value;
    logic       lookup;
    logic [7:0] key;
    logic       modify;
    logic       del;
    logic [7:0] mod_value;
    logic       valid;
    logic [7:0] res;

    int checks   = 0;
    int failures = 0;

    kvs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (busy),
        .insert    (insert),
        .ins_key   (ins_key),
        .ins_value (ins_value),
        .lookup    (lookup),
        .key       (key),
        .modify    (modify),
        .del       (del),
        .mod_value (mod_value),
        .valid     (valid),
        .res       (res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ins(input logic [7:0] k, input logic [7:0] v);
        insert    = 1'b1;
        ins_key   = k;
        ins_value = v;
    endtask

    task automatic do_lk(input logic [7:0] k);
        lookup = 1'b1;
        key    = k;
    endtask

    initial begin
        rst_n = 1'b0; insert = 1'b0; ins_key = '0; ins_value = '0;
        lookup = 1'b0; key = '0; modify = 1'b0; del = 1'b0; mod_value = '0;
        cyc(); cyc();
        rst_n = 1'b1;
        chk("reset_valid", valid, 0);
        chk("reset_res", res, 0);
        chk("reset_busy", busy, 0);

        // insert 0x12 -> lookup hit
        do_ins(8'h12, 8'h34);
        cyc();
        chk("t1_busy", busy, 1);
        insert = 1'b0; do_lk(8'h12);
        cyc();
        chk("t1_busy_clear", busy, 0);
        chk("t1_idle_valid", valid, 0);
        lookup = 1'b0;
        cyc();
        chk("t1_hit", valid, 1);
        chk("t1_res", res, 8'h34);

        // same-cycle insert/lookup misses; insert while busy is refused
        do_ins(8'h55, 8'h66); do_lk(8'h55);
        cyc();
        chk("t2_busy", busy, 1);
        do_ins(8'h77, 8'h99);
        cyc();
        chk("t2_same_cycle_miss", valid, 0);
        chk("t2_busy_after", busy, 0);
        insert = 1'b0; lookup = 1'b0;
        cyc();
        chk("t2_next_hit", valid, 1);
        chk("t2_next_res", res, 8'h66);
        cyc();

        // modify forwarded to in-flight and same-cycle lookups
        do_lk(8'h12);
        cyc();
        do_lk(8'h12);
        cyc();
        chk("t3_first_valid", valid, 1);
        chk("t3_first_res", res, 8'h34);
        modify = 1'b1; mod_value = 8'hAA; do_lk(8'h12);
        cyc();
        modify = 1'b0; lookup = 1'b0;
        chk("t3_fwd_valid", valid, 1);
        chk("t3_fwd_res", res, 8'hAA);
        cyc();
        chk("t3_incoming_valid", valid, 1);
        chk("t3_incoming_res", res, 8'hAA);
        cyc();

        // delete forwarded
        do_lk(8'h12);
        cyc();
        do_lk(8'h12);
        cyc();
        chk("t4_pre_valid", valid, 1);
        chk("t4_pre_res", res, 8'hAA);
        modify = 1'b1; del = 1'b1; do_lk(8'h12);
        cyc();
        modify = 1'b0; del = 1'b0;
        chk("t4_fwd_del", valid, 0);
        do_lk(8'h12);
        cyc();
        lookup = 1'b0;
        chk("t4_incoming_del", valid, 0);
        cyc();
        chk("t4_storage_del", valid, 0);
        cyc();

        // collisions: 0x10 -> T0[1], 0x01 -> T1[2], 0x23 has both full -> dropped
        do_ins(8'h10, 8'h11);
        cyc();
        insert = 1'b0;
        cyc();
        do_ins(8'h01, 8'h22);
        cyc();
        insert = 1'b0;
        cyc();
        do_ins(8'h23, 8'h33);
        cyc();
        insert = 1'b0;
        cyc();
        do_lk(8'h10);
        cyc();
        do_lk(8'h01);
        cyc();
        chk("t5_k10_valid", valid, 1);
        chk("t5_k10_res", res, 8'h11);
        do_lk(8'h23);
        cyc();
        chk("t5_k01_valid", valid, 1);
        chk("t5_k01_res", res, 8'h22);
        do_lk(8'h77);
        cyc();
        chk("t5_k23_dropped", valid, 0);
        do_lk(8'h55);
        cyc();
        chk("t5_k77_refused", valid, 0);
        lookup = 1'b0;
        cyc();
        chk("t5_k55_valid", valid, 1);
        chk("t5_k55_res", res, 8'h66);

        // async reset with lookups in flight
        do_lk(8'h10);
        cyc();
        do_lk(8'h01);
        cyc();
        chk("t6_pre_valid", valid, 1);
        lookup = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_res", res, 0);
        chk("t6_rst_busy", busy, 0);
        cyc();
        rst_n = 1'b1;
        chk("t6_post_valid", valid, 0);
        do_lk(8'h10);
        cyc();
        do_lk(8'h01);
        cyc();
        do_lk(8'h55);
        chk("t6_k10_miss", valid, 0);
        cyc();
        lookup = 1'b0;
        chk("t6_k01_miss", valid, 0);
        cyc();
        chk("t6_k55_miss", valid, 0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kvs.md
Name: kvs

Overview:
- Pipelined multi-table hash map (d-left style) storing up to NUM_TABLES*2^NUM_ADDR_BITS key/value pairs.
- Insert port: rate-limited by busy.
- Lookup port: returns hit/value NUM_PIPES cycles after the request.
- Modify/delete: issued on the cycle the lookup result appears; act on the slot that lookup found.
- Intended as the keyed-state store for streaming datapaths.

Parameters:
- NUM_KEY_BITS, 8, key width.
- NUM_VAL_BITS, 8, value width.
- NUM_PIPES, 2, lookup latency in cycles (>=1).
- NUM_TABLES, 2, number of hash tables (>=1).
- NUM_ADDR_BITS, 4, address bits per table.
- EN_INS_SEL, 1, insert table-selection mode (see Behaviour).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- busy  out  1  insert not accepted this cycle.
- insert  in  1  insert request; accepted when insert && !busy.
- ins_key  in  NUM_KEY_BITS  key to insert.
- ins_value  in  NUM_VAL_BITS  value to insert.
- lookup  in  1  lookup request.
- key  in  NUM_KEY_BITS  lookup key.
- modify  in  1  modify/delete the slot found by the lookup whose result is presented this cycle.
- del  in  1  with modify: delete instead of overwrite.
- mod_value  in  NUM_VAL_BITS  new value for modify.
- valid  out  1  lookup hit, NUM_PIPES cycles after the request.
- res  out  NUM_VAL_BITS  lookup value; meaningful only when valid.

Behaviour:
- Storage: per table, 2^NUM_ADDR_BITS slots of {occupied, key, value}, held in registers.
- Hash for table i: rotate key left by i bits, then XOR-fold into NUM_ADDR_BITS bits (chunks from the LSB, last chunk zero-padded).
- Reset (async, rst_n=0):
  - all occupied bits, lookup pipeline and busy cleared;
  - valid=0, res=0, busy=0;
  - a reset mid-operation discards all in-flight lookups and modifies.
- Insert, accepted at edge t when insert && !busy:
  - EN_INS_SEL=1: written to the lowest-index table whose hashed slot is unoccupied.
  - EN_INS_SEL=0: written to the table named by a round-robin counter that advances per accepted insert.
  - Target slot occupied (or all candidate slots full): insert silently dropped.
  - busy=1 for exactly the one cycle after every accepted insert; otherwise 0.
  - Inserting a key already present is illegal; behaviour undefined.
- Lookup, issued at cycle t:
  - Result reflects table state at cycle t, after all inserts accepted before t.
  - An insert of the same key in cycle t is NOT visible (miss).
  - Result appears combinationally on valid/res during cycle t+NUM_PIPES.
  - Pipeline records hit, table index, address and value.
  - Fully pipelined: one lookup per cycle, independent of busy.
  - lookup=0 yields valid=0 in the matching output cycle.
- Modify/delete:
  - Honoured only in a cycle where the presented result has valid=1; ignored otherwise.
  - modify&&!del writes mod_value to the recorded slot; modify&&del clears occupied.
- Forwarding:
  - A modify/delete at cycle m for a lookup issued at t must be reflected in every in-flight lookup of the same key issued at t+1..m.
  - Implementation: patch matching pipeline entries (same table/addr) at m.
  - Enables back-to-back read-modify-write on one key.
- Same-cycle insert and lookup on different keys: both proceed.

Optional Feature:
- KVS_FORMAL_EN defined:
  - adds input f_key [NUM_KEY_BITS-1:0];
  - enables internal immediate assertions: f_key occupies at most one slot across all tables; forwarded pipeline value for f_key matches storage.
- Undefined: no f_key port, no assertions; synthesizable logic identical.

Test Plan:
- Reset, insert key 0x12 val 0x34 at t; lookup 0x12 at t+1 -> valid=1, res=0x34 at t+3; busy=1 only at t+1.
- Insert 0x55 and lookup 0x55 in same cycle -> valid=0 two cycles later; lookup next cycle -> hit.
- Lookup 0x12 at t and t+1; at t+2 modify=1, mod_value=0xAA -> second result (t+3) valid=1, res=0xAA.
- Lookup 0x12 at t, del at t+2 -> lookups issued t+1 onward return valid=0.
- Insert 0x01 (EN_INS_SEL=1) into filled colliding slots -> lands in next table; when all candidate slots full, insert dropped and lookup misses.
- Assert rst_n=0 with lookups in flight -> valid=0 immediately; all keys miss after reset.
